// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial system bus transmit/receive blocks.
// Contents:
//   tx_state_e    - frame FSM state encoding (3-bit)
//   IDLE_LEVEL    - line level between frames
//   START_LEVEL   - line level of the start bit
//   frame_cycles  - clk cycles from the start-bit edge to the frame_done cycle
package serial_bus_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  function automatic int unsigned frame_cycles(input int unsigned data_width,
                                               input int unsigned clks_per_bit,
                                               input int unsigned parity_en);
    return clks_per_bit * (2 + data_width + parity_en);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer shared by the serial transmitter and receiver.
// Ports:
//   clk     - clock, rising edge
//   rstn    - asynchronous active-low reset
//   clear   - holds the count at 0 (used while the line is idle)
//   bit_end - high during the last cycle of each CLKS_PER_BIT-cycle bit period
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  assign bit_end = (count_q == LAST);

  // Restarting at every bit end keeps the count from wrapping inside a state and
  // leaves it at 0 on every state change, since states only change at bit ends.
  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || bit_end) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from a FIFO read port and sends each as a UART-style frame:
// start bit, data LSB first, optional even parity bit, stop bit.
// Ports:
//   clk        - clock, rising edge
//   rstn       - asynchronous active-low reset
//   en         - allows new frames to start; a frame in progress always completes
//   fifo_empty - FIFO empty flag
//   fifo_data  - FIFO head word, valid while fifo_empty is low
//   fifo_deq   - combinational pop strobe, one cycle per frame
//   tx         - registered serial line, idles high
//   busy       - registered, high while a frame is on the line
//   frame_done - registered one-cycle pulse in the first idle cycle after a frame
module fifo_serial_tx
  import serial_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_deq,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned IW = $clog2(DATA_WIDTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q;
  logic                  done_q;
  logic                  bit_end;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (state_q == StIdle),
    .bit_end(bit_end)
  );

  // rstn is folded in so no pop is signalled while the block is held in reset.
  assign fifo_deq = (state_q == StIdle) && en && !fifo_empty && rstn;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    idx_d    = idx_q;

    unique case (state_q)
      StIdle: begin
        if (fifo_deq) begin
          shift_d  = fifo_data;
          parity_d = ^fifo_data;
          idx_d    = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Line level follows the state being entered so tx lines up with state_q.
    unique case (state_d)
      StStart:  tx_d = START_LEVEL;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = parity_d;
      default:  tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      parity_q <= 1'b0;
      idx_q    <= '0;
      tx_q     <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      busy_q   <= (state_d != StIdle);
      done_q   <= (state_q == StStop) && (state_d == StIdle);
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx: one instance without parity, one with
// even parity, each fed by a small array-based FIFO model.
module tb_fifo_serial_tx;
  import serial_bus_pkg::*;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  int         wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  int         deq_cnt_a = 0, deq_cnt_b = 0;

  logic       empty_a, empty_b, deq_a, deq_b;
  logic [7:0] data_a, data_b;
  logic       tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  int         checks = 0, passes = 0, fails = 0;
  bit         use_b = 1'b0;
  logic       m_tx, m_busy, m_done, m_deq;

  always #5 clk = ~clk;

  assign empty_a = (wr_a == rd_a);
  assign empty_b = (wr_b == rd_b);
  assign data_a  = mem_a[rd_a % 16];
  assign data_b  = mem_b[rd_b % 16];

  assign m_tx   = use_b ? tx_b   : tx_a;
  assign m_busy = use_b ? busy_b : busy_a;
  assign m_done = use_b ? done_b : done_a;
  assign m_deq  = use_b ? deq_b  : deq_a;

  always @(posedge clk) begin
    if (deq_a) begin
      rd_a      <= rd_a + 1;
      deq_cnt_a <= deq_cnt_a + 1;
    end
    if (deq_b) begin
      rd_b      <= rd_b + 1;
      deq_cnt_b <= deq_cnt_b + 1;
    end
  end

  fifo_serial_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB),
    .PARITY_EN   (0)
  ) dut_a (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .fifo_empty(empty_a),
    .fifo_data (data_a),
    .fifo_deq  (deq_a),
    .tx        (tx_a),
    .busy      (busy_a),
    .frame_done(done_a)
  );

  fifo_serial_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB),
    .PARITY_EN   (1)
  ) dut_b (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .fifo_empty(empty_b),
    .fifo_data (data_b),
    .fifo_deq  (deq_b),
    .tx        (tx_b),
    .busy      (busy_b),
    .frame_done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] w);
    mem_a[wr_a % 16] = w;
    wr_a = wr_a + 1;
  endtask

  task automatic push_b(input logic [7:0] w);
    mem_b[wr_b % 16] = w;
    wr_b = wr_b + 1;
  endtask

  // Counts falling edges of clk until the selected line goes low (bounded).
  task automatic wait_fall(output int waited);
    waited = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      waited++;
      if (m_tx === 1'b0) break;
    end
  endtask

  // Expects the start bit on the next cycle, then checks every line cycle and
  // the frame_done pulse at the frame length. en is dropped at cycle drop_at.
  task automatic frame_check(input string name, input logic [7:0] w, input int par,
                             input int drop_at);
    int waited;
    int ncyc;
    int bad;
    int j;
    logic e;
    bad  = 0;
    ncyc = int'(frame_cycles(8, CPB, par));
    wait_fall(waited);
    chk($sformatf("%s_start_delay", name), waited, 1);
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk);
      j = c / CPB;
      if (j == 0)                  e = 1'b0;
      else if (j <= 8)             e = w[j-1];
      else if (par != 0 && j == 9) e = ^w;
      else                         e = 1'b1;
      chk($sformatf("%s_tx_c%0d", name, c), m_tx, e);
      if (m_busy !== 1'b1 || m_done !== 1'b0 || m_deq !== 1'b0) bad++;
      if (c == drop_at) en = 1'b0;
    end
    chk($sformatf("%s_ctl_in_frame", name), bad, 0);
    @(negedge clk);
    chk($sformatf("%s_frame_done", name), m_done, 1);
    chk($sformatf("%s_busy_after", name), m_busy, 0);
    chk($sformatf("%s_tx_after", name), m_tx, 1);
  endtask

  initial begin
    int base;
    int bad;
    int waited;

    // Reset: outputs idle and no pop even with a word waiting and en high.
    en = 1'b1;
    push_a(8'hA5);
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_deq", deq_a, 0);

    // Single word 0xA5.
    base = deq_cnt_a;
    rstn = 1'b1;
    #1;
    chk("single_deq", deq_a, 1);
    frame_check("single", 8'hA5, 0, -1);
    chk("single_deq_cnt", deq_cnt_a - base, 1);

    // Even parity: 0x07 -> parity 1, 0x03 -> parity 0.
    use_b = 1'b1;
    push_b(8'h07);
    frame_check("par07", 8'h07, 1, -1);
    repeat (2) @(negedge clk);
    push_b(8'h03);
    frame_check("par03", 8'h03, 1, -1);
    chk("par_deq_cnt", deq_cnt_b, 2);
    use_b = 1'b0;

    // Back-to-back: exactly one idle cycle between frames.
    repeat (2) @(negedge clk);
    base = deq_cnt_a;
    push_a(8'h01);
    push_a(8'h02);
    push_a(8'h03);
    frame_check("b2b1", 8'h01, 0, -1);
    frame_check("b2b2", 8'h02, 0, -1);
    frame_check("b2b3", 8'h03, 0, -1);
    chk("b2b_deq_cnt", deq_cnt_a - base, 3);
    chk("b2b_empty", empty_a, 1);

    // Gating by en.
    en = 1'b0;
    push_a(8'h3C);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (deq_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    chk("gate_idle", bad, 0);
    base = deq_cnt_a;
    en = 1'b1;
    #1;
    chk("gate_deq_same_cycle", deq_a, 1);
    frame_check("gate", 8'h3C, 0, 10);
    push_a(8'h99);
    repeat (10) @(negedge clk);
    chk("gate_no_pop_en0", deq_cnt_a - base, 1);
    chk("gate_tx_en0", tx_a, 1);
    en = 1'b1;
    frame_check("gate99", 8'h99, 0, -1);

    // Reset during DATA bit 3 of 0xC3 (bit 3 is 0, so tx must jump high).
    repeat (2) @(negedge clk);
    push_a(8'hC3);
    wait_fall(waited);
    chk("rstmid_start_delay", waited, 1);
    repeat (17) @(negedge clk);
    chk("rstmid_tx_before", tx_a, 0);
    rstn = 1'b0;
    #1;
    chk("rstmid_tx_async", tx_a, 1);
    chk("rstmid_busy_async", busy_a, 0);
    repeat (3) @(negedge clk);
    base = deq_cnt_a;
    rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b0) bad++;
    end
    chk("rstmid_quiet", bad, 0);
    chk("rstmid_no_repop", deq_cnt_a - base, 0);
    push_a(8'h5A);
    frame_check("after_rst", 8'h5A, 0, -1);

    // Empty FIFO for 100 cycles.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (deq_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || tx_a !== 1'b1) bad++;
    end
    chk("empty_quiet", bad, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
